// File: rtl/decoder_onehot_stream.sv
// ----------------------------------------------------------------------------
// decoder_onehot_stream
//   Pipelined select-code decoder. Each accepted request (in_sel, in_mode) is
//   decoded into a one-hot, thermometer, inverted one-hot or accumulated mask
//   and stored in a 2-entry FIFO that drives the output stream.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; flushes the FIFO and the accumulator
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready (low while rst=1 or FIFO full)
//   in_sel     select code
//   in_mode    00 one-hot, 01 thermometer, 10 inverted one-hot, 11 accumulate
//   acc_clr    clears the accumulator (before the OR of a same-cycle mode-11 accept)
//   out_valid  head entry valid
//   out_ready  downstream accepts the head entry
//   out_data   decoded mask of the head entry
//   out_err    head entry had an out-of-range select (in_sel >= OUT_W)
//   acc_mask   current accumulator contents
// ----------------------------------------------------------------------------
module decoder_onehot_stream #(
    parameter int SEL_W = 5,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [1:0]       in_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [OUT_W-1:0] acc_mask
);

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERMO = 2'b01;
    localparam logic [1:0] MODE_INVERT = 2'b10;
    localparam logic [1:0] MODE_ACC    = 2'b11;

    // One extra bit so that OUT_W == 2**SEL_W is representable.
    localparam logic [SEL_W:0] OUT_LIMIT = (SEL_W + 1)'(OUT_W);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_r;
    logic [OUT_W-1:0] head_data_r;
    logic             head_err_r;
    logic [OUT_W-1:0] tail_data_r;
    logic             tail_err_r;
    logic [OUT_W-1:0] acc_r;

    logic             accept_s;
    logic             pop_s;
    logic [OUT_W-1:0] acc_base_s;
    logic [OUT_W-1:0] acc_next_s;
    logic [OUT_W-1:0] dec_data_s;
    logic             dec_err_s;

    // Returns {err, mask}. An out-of-range select yields an all-zero mask in
    // every mode. In accumulate mode the mask is the new accumulator value.
    function automatic logic [OUT_W:0] decode_sel(
        input logic [SEL_W-1:0] sel,
        input logic [1:0]       mode,
        input logic [OUT_W-1:0] acc_base
    );
        logic [SEL_W:0]   sel_ext;
        logic [SEL_W:0]   idx;
        logic [OUT_W-1:0] onehot;
        logic [OUT_W-1:0] thermo;
        logic [OUT_W-1:0] data;
        logic             err;
        sel_ext = {1'b0, sel};
        onehot  = {OUT_W{1'b0}};
        thermo  = {OUT_W{1'b0}};
        for (int i = 0; i < OUT_W; i++) begin
            idx       = (SEL_W + 1)'(i);
            onehot[i] = (idx == sel_ext);
            thermo[i] = (idx <= sel_ext);
        end
        err = (sel_ext >= OUT_LIMIT);
        if (err) begin
            data = {OUT_W{1'b0}};
        end else begin
            case (mode)
                MODE_ONEHOT: data = onehot;
                MODE_THERMO: data = thermo;
                MODE_INVERT: data = ~onehot;
                MODE_ACC:    data = acc_base | onehot;
                default:     data = {OUT_W{1'b0}};
            endcase
        end
        return {err, data};
    endfunction

    // Handshake qualifiers and output flags derived from the registered state.
    assign in_ready  = ~rst & (state_r != ST_TWO);
    assign out_valid = (state_r != ST_EMPTY);
    assign out_data  = head_data_r;
    assign out_err   = head_err_r;
    assign acc_mask  = acc_r;

    // Decode the incoming request and compute the next accumulator value.
    always_comb begin
        accept_s   = in_valid & in_ready;
        pop_s      = out_valid & out_ready;
        acc_base_s = acc_clr ? {OUT_W{1'b0}} : acc_r;
        {dec_err_s, dec_data_s} = decode_sel(in_sel, in_mode, acc_base_s);
        if (accept_s && (in_mode == MODE_ACC) && !dec_err_s) begin
            acc_next_s = dec_data_s;
        end else begin
            acc_next_s = acc_base_s;
        end
    end

    // Occupancy FSM, 2-entry FIFO storage and accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            head_data_r <= {OUT_W{1'b0}};
            head_err_r  <= 1'b0;
            tail_data_r <= {OUT_W{1'b0}};
            tail_err_r  <= 1'b0;
            acc_r       <= {OUT_W{1'b0}};
        end else begin
            acc_r <= acc_next_s;
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_data_r <= dec_data_s;
                        head_err_r  <= dec_err_s;
                        state_r     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        // Head leaves and the new entry becomes the head.
                        head_data_r <= dec_data_s;
                        head_err_r  <= dec_err_s;
                    end else if (accept_s) begin
                        tail_data_r <= dec_data_s;
                        tail_err_r  <= dec_err_s;
                        state_r     <= ST_TWO;
                    end else if (pop_s) begin
                        // Head keeps the last popped value while empty.
                        state_r <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        head_data_r <= tail_data_r;
                        head_err_r  <= tail_err_r;
                        state_r     <= ST_ONE;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
